// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: FSM states, word/lane widths
// and the alignment helper.
package mem_pkg;

  localparam int XLEN = 32;
  localparam int BE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } resp_state_t;

  // Word accesses only: the two low byte-address bits must be zero.
  function automatic logic is_aligned(input logic [1:0] addr_lo);
    return (addr_lo == 2'b00);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised data array with per-byte write enables and a registered read
// port. Contents are deliberately left unreset.
module dmem_array
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [BE_W-1:0] be,
  input  logic [AW-1:0]   widx,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   ridx,
  output logic [XLEN-1:0] rdata
);

  logic [XLEN-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    rdata <= mem[ridx];
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory slave: accepts a load/store, waits LATENCY
// cycles, then presents a registered response until the requester takes it.
module dmem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [BE_W-1:0] req_be,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  resp_state_t     state, state_next;
  logic [3:0]      cnt, cnt_next;
  logic            write_q, err_q, load_ok_q;
  logic [AW-1:0]   widx_q;
  logic            accept, acc_err, arr_we;
  logic [AW-1:0]   req_widx, ridx;
  logic [XLEN-1:0] arr_rdata;

  assign accept   = (state == IDLE) && req_valid && req_ready;
  assign acc_err  = !is_aligned(req_addr[1:0]) || (req_addr[XLEN-1:2] >= 30'(DEPTH_WORDS));
  assign req_widx = req_addr[AW+1:2];
  assign arr_we   = accept && req_write && !acc_err;

  // The array is read at the acceptance edge and then keeps re-reading the latched
  // index; no write can occur until the response completes, so its output stays stable.
  assign ridx = (state == IDLE) ? req_widx : widx_q;

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk  (clk),
    .we   (arr_we),
    .be   (req_be),
    .widx (req_widx),
    .wdata(req_wdata),
    .ridx (ridx),
    .rdata(arr_rdata)
  );

  assign rsp_rdata = load_ok_q ? arr_rdata : '0;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 0) begin
            state_next = RESP;
          end else begin
            state_next = WAIT;
            cnt_next   = 4'(LATENCY);
          end
        end
      end
      WAIT: begin
        cnt_next = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          state_next = RESP;
          cnt_next   = 4'd0;
        end
      end
      RESP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs are decoded from the next state so they are plain flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      load_ok_q <= 1'b0;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      widx_q    <= '0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      req_ready <= (state_next == IDLE);
      rsp_valid <= (state_next == RESP);
      if (accept) begin
        write_q <= req_write;
        err_q   <= acc_err;
        widx_q  <= req_widx;
      end
      rsp_err   <= (state_next == RESP) && (accept ? acc_err : err_q);
      load_ok_q <= (state_next == RESP) &&
                   (accept ? (!req_write && !acc_err) : (!write_q && !err_q));
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed and randomized checks of dmem_responder against a word-array model.
module tb_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;
  bit [31:0] model_mem [DEPTH];

  dmem_responder #(
    .DEPTH_WORDS(DEPTH),
    .LATENCY    (LAT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_be   (req_be),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transaction: model update, drive, latency measurement, hold, handshake.
  task automatic apply_stimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                                input logic [3:0] be, input int hold);
    int          edges;
    int          idx;
    logic        exp_err;
    logic [31:0] exp_data;
    idx      = int'(addr >> 2);
    exp_err  = (addr[1:0] != 2'b00) || (idx >= DEPTH);
    exp_data = 32'h0;
    if (!exp_err) begin
      if (wr) begin
        for (int i = 0; i < 4; i++) if (be[i]) model_mem[idx][8*i +: 8] = wd[8*i +: 8];
      end else begin
        exp_data = model_mem[idx];
      end
    end
    edges = 0;
    @(negedge clk);
    while (!req_ready && edges < 20) begin
      @(negedge clk);
      edges++;
    end
    check_output("req_ready_before_accept", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    req_be    = be;
    @(posedge clk);
    #1;
    req_valid = 1'($urandom);
    req_write = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_be    = 4'($urandom);
    edges = 1;
    @(negedge clk);
    while (!rsp_valid && edges < 40) begin
      check_output("req_ready_in_wait", 32'(req_ready), 32'd0);
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check_output("rsp_latency", 32'(edges), 32'(LAT + 1));
    check_output("rsp_rdata", rsp_rdata, exp_data);
    check_output("rsp_err", 32'(rsp_err), 32'(exp_err));
    repeat (hold) begin
      @(negedge clk);
      check_output("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      check_output("hold_rsp_rdata", rsp_rdata, exp_data);
      check_output("hold_rsp_err", 32'(rsp_err), 32'(exp_err));
      check_output("hold_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    check_output("rsp_valid_after_hs", 32'(rsp_valid), 32'd0);
    check_output("req_ready_after_hs", 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] addr;
    reset     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    req_be    = 4'h0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_output("reset_req_ready", 32'(req_ready), 32'd0);
    check_output("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check_output("reset_rsp_rdata", rsp_rdata, 32'd0);
    check_output("reset_rsp_err", 32'(rsp_err), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_output("release_req_ready", 32'(req_ready), 32'd1);

    $display("[TB] directed transactions");
    apply_stimulus(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    apply_stimulus(1'b0, 32'h10, 32'h0, 4'h0, 0);
    apply_stimulus(1'b1, 32'h10, 32'h000000AA, 4'b0001, 0);
    apply_stimulus(1'b0, 32'h10, 32'h0, 4'h0, 0);
    check_output("merged_word_model", model_mem[4], 32'hDEADBEAA);
    apply_stimulus(1'b0, 32'h12, 32'h0, 4'h0, 0);
    apply_stimulus(1'b0, 32'h10, 32'h0, 4'h0, 0);

    for (int w = 0; w < 64; w++) begin
      if (w != 4) apply_stimulus(1'b1, 32'(w) << 2, $urandom, 4'hF, 0);
    end
    apply_stimulus(1'b1, 32'(DEPTH) << 2, 32'hFFFF_FFFF, 4'hF, 0);
    apply_stimulus(1'b0, 32'h0, 32'h0, 4'h0, 0);
    apply_stimulus(1'b0, 32'h10, 32'h0, 4'h0, 0);
    apply_stimulus(1'b1, 32'h14, 32'h5555_AAAA, 4'h0, 0);
    apply_stimulus(1'b0, 32'h14, 32'h0, 4'h0, 5);

    $display("[TB] reset during wait");
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h20;
    req_wdata = 32'h1234_5678;
    req_be    = 4'hF;
    model_mem[8] = 32'h1234_5678;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    check_output("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
    check_output("midreset_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_output("post_reset_req_ready", 32'(req_ready), 32'd1);
    check_output("post_reset_rsp_valid", 32'(rsp_valid), 32'd0);
    apply_stimulus(1'b0, 32'h20, 32'h0, 4'h0, 0);

    $display("[TB] randomized transactions");
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 5))
        0:       addr = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
        1:       addr = 32'($urandom_range(DEPTH, 1 << 20)) << 2;
        default: addr = 32'($urandom_range(0, 63)) << 2;
      endcase
      apply_stimulus(1'($urandom), addr, $urandom, 4'($urandom), int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the CPU data-load/store interface. It accepts one request at a time over a valid/ready handshake, inserts a programmable number of wait states, and returns read data or a write acknowledgement over a response handshake. It is the slave end of the data path that the pipelined core drives once data memory moves off the combinational `ram` model. It supports byte-enabled writes, alignment checking and range checking.

## Interface
- `DEPTH_WORDS`, 1024: number of 32-bit words; power of two, minimum 4.
- `LATENCY`, 2: wait-state cycles between acceptance and response; range 0–15.
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: responder can accept a request.
- `req_write` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, little-endian lanes.
- `req_be` in 4: byte enables; bit i enables lane i (bits 8i+7:8i). Ignored for loads.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: requester accepts the response.
- `rsp_rdata` out 32: load data; 0 for stores and errors.
- `rsp_err` out 1: the request was misaligned or out of range.

## Operation
- FSM states are IDLE, WAIT and RESP. A reset forces the FSM to IDLE.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`&&`req_ready`, latch write, word index `req_addr[31:2]` and the error flag.
  - Go to WAIT and load the wait counter with `LATENCY`. If `LATENCY`=0, go straight to RESP.
- WAIT:
  - `req_ready`=0.
  - The counter decrements each cycle. When it reaches 0 (the counter is at 1 at the edge), go to RESP.
- RESP:
  - `rsp_valid`=1. `rsp_rdata` and `rsp_err` are held stable until `rsp_ready`=1.
  - On that edge, go to IDLE.
  - No new request is accepted in the same cycle as the response handshake. There is at most one transaction in flight.
- Error rule: `req_addr[1:0]`≠0, or word index ≥ `DEPTH_WORDS`.
  - The memory is not modified.
  - `rsp_rdata`=0 and `rsp_err`=1.
- Store:
  - On the acceptance edge, write each lane whose `req_be` bit is set. Other lanes keep their old value.
  - `req_be`=0 is legal: no change, and a normal response is returned.
- Load: the full 32-bit word is captured into the `rsp_rdata` register on the edge that enters RESP. It reflects every store accepted earlier.
- Request inputs are sampled only at acceptance. Changes while in WAIT or RESP have no effect.
- Memory contents are not reset and are undefined at power-up.

## Timing
- Reset values: `req_ready`=0 while `reset` is low and 1 in the first cycle after release; `rsp_valid`=0; `rsp_rdata`=0; `rsp_err`=0; counter=0.
- `rsp_valid` rises `LATENCY`+1 cycles after the acceptance edge.
  - With `LATENCY`=0 it rises the cycle after acceptance.
  - The minimum transaction period is `LATENCY`+2 cycles when `rsp_ready` is held high.
- `rsp_valid` falls on the edge where `rsp_ready`=1 is sampled. `req_ready` rises on that same edge.
- Reset asserted mid-transaction:
  - `rsp_valid` and `req_ready` drop immediately (asynchronously).
  - The pending response is discarded.
  - A store already accepted stays committed.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- The shared package `mem_pkg` holds:
  - the `resp_state_t` enum (IDLE/WAIT/RESP);
  - `XLEN`=32 and `BE_W`=4;
  - the helper function `is_aligned`.
- Sub-module `dmem_array`:
  - synchronous byte-write array with ports `clk`, `we`, `be`, `widx`, `wdata`, `ridx`, `rdata`;
  - read-data registered, with no reset.
- The top level contains the FSM, the wait counter, the error check and the response registers.

## Test plan
- Reset release, `LATENCY`=2, store `req_addr`=0x10, `req_wdata`=0xDEADBEEF, `req_be`=4'hF:
  - `rsp_valid` rises 3 cycles after acceptance;
  - `rsp_err`=0 and `rsp_rdata`=0.
- Load from 0x10 → `rsp_rdata`=0xDEADBEEF. Then store 0x000000AA with `req_be`=4'b0001, then load → 0xDEADBEAA.
- Load from 0x12 (misaligned) → `rsp_err`=1 and `rsp_rdata`=0. A following load from 0x10 is unchanged.
- Store to word index `DEPTH_WORDS` (0x1000 for the default) → `rsp_err`=1, and no word in the array changes.
- Hold `rsp_ready`=0 for 5 cycles → `rsp_valid`, `rsp_rdata` and `rsp_err` remain stable and `req_ready` stays 0.
  - Raise `rsp_ready` → `rsp_valid` drops on that edge and `req_ready`=1.
- Assert `reset` in WAIT after a store → `rsp_valid`=0 immediately and the FSM is in IDLE after release. A load of the stored address returns the new data.
